sa_out_ser: RTL and testbench
=============================

SA_OUT_SER -- requirements
Module: sa_out_ser

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, meaning the matrix dimension.
REQ-002 The block SHALL have parameter O_WIDTH, default 60, meaning the input element width.
REQ-003 The block SHALL have parameter OUT_WIDTH, default 32, meaning the streamed element width; OUT_WIDTH <= O_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port i_matrix_vld, input, 1 bit: a one-cycle pulse marking a result matrix.
REQ-007 The block SHALL have port i_matrix, input, [SIZE][SIZE] x O_WIDTH: the result matrix, indexed [row][col].
REQ-008 The block SHALL have port o_dat_vld, output, 1 bit: stream data valid.
REQ-009 The block SHALL have port i_dat_rdy, input, 1 bit: stream consumer ready.
REQ-010 The block SHALL have port o_dat, output, OUT_WIDTH bits: the stream element.
REQ-011 The block SHALL have ports o_row and o_col, output, clog2(SIZE) bits each: the indices of the current element.
REQ-012 The block SHALL have port o_last, output, 1 bit: high on element [SIZE-1][SIZE-1].
REQ-013 The block SHALL have port o_drop, output, 1 bit: a one-cycle pulse flagging a discarded matrix.
REQ-014 The block SHALL have port o_drop_cnt, output, 8 bits: the saturating count of dropped matrices.

Function
REQ-015 The block SHALL hold two matrix entries (ping-pong) with full flags, a write pointer and a read pointer.
REQ-016 On the i_matrix_vld edge, the block SHALL copy i_matrix into the entry at the write pointer, set its full flag and toggle the write pointer, provided that entry is free.
REQ-017 The block SHALL drive o_dat_vld high exactly when the entry at the read pointer is full; for a capture into an empty block, first o_dat_vld appears one cycle after the i_matrix_vld cycle.
REQ-018 The block SHALL stream elements row-major, [0][0], [0][1], ... [SIZE-1][SIZE-1], advancing the element index only on o_dat_vld & i_dat_rdy.
REQ-019 While o_dat_vld=1 and i_dat_rdy=0, o_dat, o_row, o_col and o_last SHALL hold stable.
REQ-020 On transfer of the last element, the block SHALL clear the read entry's full flag, toggle the read pointer and reset the index to 0; the next entry, if full, SHALL stream back-to-back with no bubble.
REQ-021 When i_matrix_vld arrives with both entries full, the block SHALL discard the matrix, pulse o_drop for one cycle and increment o_drop_cnt, which saturates at 255.
REQ-022 When i_matrix_vld arrives with both entries full in the same cycle as the last-element transfer, the block SHALL accept the matrix into the freed entry with no drop.
REQ-023 A capture SHALL never modify the entry being streamed.
REQ-024 With SA_OUT_SER_SAT_EN undefined, o_dat SHALL equal the low OUT_WIDTH bits of the element.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear both full flags and both pointers, the index, o_dat_vld, o_drop and o_drop_cnt, and SHALL set o_dat, o_row, o_col and o_last to 0.
REQ-026 Reset asserted mid-stream SHALL abandon the current and buffered matrices; after release, no element SHALL be emitted until a new i_matrix_vld.
REQ-027 The entry storage SHALL not require reset.

Configuration
REQ-028 With macro SA_OUT_SER_SAT_EN defined, the block SHALL treat elements as unsigned and clamp o_dat to 2^OUT_WIDTH-1 whenever any of bits O_WIDTH-1..OUT_WIDTH is set.
REQ-029 With SA_OUT_SER_SAT_EN undefined, the block SHALL truncate per REQ-024 and contain no saturation logic.

Verification
REQ-030 Scenario: SIZE=4, element[r][c]=4r+c, i_dat_rdy=1 -> 16 beats with values 0..15 on consecutive cycles, o_last on beat 15, o_row/o_col matching.
REQ-031 Scenario: i_dat_rdy toggles 1,0,1,0 -> each o_dat holds while not ready; value sequence identical to the previous scenario.
REQ-032 Scenario: three i_matrix_vld pulses 2 cycles apart with i_dat_rdy=0 -> third causes an o_drop pulse and o_drop_cnt=1; raising rdy streams matrices 1 and 2 back-to-back (32 beats, no gap).
REQ-033 Scenario: both entries full, i_matrix_vld coincident with the last-beat transfer -> no o_drop; three full matrices are streamed.
REQ-034 Scenario: element=2^40+5, OUT_WIDTH=32 -> o_dat=5 with the macro undefined; o_dat=0xFFFFFFFF with SA_OUT_SER_SAT_EN defined.
REQ-035 Scenario: rst_n pulsed low at beat 7 -> o_dat_vld drops asynchronously and o_drop_cnt=0; no beats follow until a new i_matrix_vld, which then streams from [0][0].

Source files
------------

// File: rtl/sa_out_ser.sv
// Ping-pong result-matrix buffer that streams elements row-major over a valid/ready port.
// Optional clamp to OUT_WIDTH enabled by defining SA_OUT_SER_SAT_EN.
module sa_out_ser #(
    parameter int SIZE      = 4,
    parameter int O_WIDTH   = 60,
    parameter int OUT_WIDTH = 32,
    localparam int IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_matrix_vld,
    input  logic [SIZE-1:0][SIZE-1:0][O_WIDTH-1:0]   i_matrix,
    output logic                                     o_dat_vld,
    input  logic                                     i_dat_rdy,
    output logic [OUT_WIDTH-1:0]                     o_dat,
    output logic [IDX_W-1:0]                         o_row,
    output logic [IDX_W-1:0]                         o_col,
    output logic                                     o_last,
    output logic                                     o_drop,
    output logic [7:0]                               o_drop_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef logic [SIZE-1:0][SIZE-1:0][O_WIDTH-1:0] mat_t;

    mat_t             mem_q [2];
    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             drop_q, drop_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic                 vld;
    logic                 last_el;
    logic                 xfer;
    logic                 last_xfer;
    logic                 accept;
    logic [O_WIDTH-1:0]   elem;
    logic [OUT_WIDTH-1:0] dat_fmt;

    always_comb begin
        vld       = full_q[rd_ptr_q];
        last_el   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        xfer      = vld & i_dat_rdy;
        last_xfer = xfer & last_el;
        // Both full implies wr_ptr == rd_ptr, so a last-beat transfer frees exactly the target entry.
        accept    = i_matrix_vld &
                    (~full_q[wr_ptr_q] | (last_xfer & (wr_ptr_q == rd_ptr_q)));

        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        row_d      = row_q;
        col_d      = col_q;
        drop_d     = i_matrix_vld & ~accept;
        drop_cnt_d = drop_cnt_q;

        if (xfer) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                if (row_q == LAST_IDX) begin
                    row_d            = '0;
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (accept) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= i_matrix;
        end
    end

    assign elem = mem_q[rd_ptr_q][row_q][col_q];

`ifdef SA_OUT_SER_SAT_EN
    if (O_WIDTH > OUT_WIDTH) begin : g_sat
        assign dat_fmt = (|elem[O_WIDTH-1:OUT_WIDTH]) ? '1 : elem[OUT_WIDTH-1:0];
    end else begin : g_pass
        assign dat_fmt = elem[OUT_WIDTH-1:0];
    end
`else
    assign dat_fmt = elem[OUT_WIDTH-1:0];
    if (O_WIDTH > OUT_WIDTH) begin : g_sink
        logic unused_elem_hi;
        assign unused_elem_hi = ^elem[O_WIDTH-1:OUT_WIDTH];
    end
`endif

    assign o_dat_vld  = vld;
    assign o_dat      = vld ? dat_fmt : '0;
    assign o_row      = row_q;
    assign o_col      = col_q;
    assign o_last     = vld & last_el;
    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sa_out_ser.sv
// Directed self-checking bench for sa_out_ser at default parameters.
// Expected o_dat values follow SA_OUT_SER_SAT_EN when it is defined for the build.
module tb_sa_out_ser;

    typedef logic [3:0][3:0][59:0] mat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_matrix_vld;
    mat_t       i_matrix;
    logic       o_dat_vld;
    logic       i_dat_rdy;
    logic [31:0] o_dat;
    logic [1:0] o_row;
    logic [1:0] o_col;
    logic       o_last;
    logic       o_drop;
    logic [7:0] o_drop_cnt;

    int errors = 0;
    int checks = 0;

    sa_out_ser #(.SIZE(4), .O_WIDTH(60), .OUT_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_matrix_vld (i_matrix_vld),
        .i_matrix     (i_matrix),
        .o_dat_vld    (o_dat_vld),
        .i_dat_rdy    (i_dat_rdy),
        .o_dat        (o_dat),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_last       (o_last),
        .o_drop       (o_drop),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic mat_t seq_mat(input int unsigned base);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 60'(base + 4 * r + c);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_matrix_vld = 1'b0; i_dat_rdy = 1'b0; i_matrix = '0;
        #3;
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_dat_vld); end
        checks++; if (o_dat !== 32'd0) begin errors++; $display("FAIL reset_dat got=%h exp=0", o_dat); end
        checks++; if (o_row !== 2'd0 || o_col !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", o_row, o_col); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", o_last); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", o_drop); end
        checks++; if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_dropcnt got=%0d exp=0", o_drop_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        i_dat_rdy = 1'b1;
        i_matrix = seq_mat(0); i_matrix_vld = 1'b1;
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL stream_prevld got=%b exp=0", o_dat_vld); end
        tick();
        i_matrix_vld = 1'b0;
        for (int b = 0; b < 16; b++) begin
            checks++; if (o_dat_vld !== 1'b1) begin errors++; $display("FAIL stream_vld beat=%0d got=%b exp=1", b, o_dat_vld); end
            checks++; if (o_dat !== 32'(b)) begin errors++; $display("FAIL stream_dat beat=%0d got=%0d exp=%0d", b, o_dat, b); end
            checks++; if (o_row !== 2'(b / 4) || o_col !== 2'(b % 4)) begin errors++; $display("FAIL stream_idx beat=%0d got=%0d/%0d exp=%0d/%0d", b, o_row, o_col, b / 4, b % 4); end
            checks++; if (o_last !== (b == 15)) begin errors++; $display("FAIL stream_last beat=%0d got=%b exp=%b", b, o_last, (b == 15)); end
            tick();
        end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL stream_end got=%b exp=0", o_dat_vld); end
    endtask

    task automatic test_backpressure();
        int idx;
        idx = 0;
        i_dat_rdy = 1'b0;
        i_matrix = seq_mat(0); i_matrix_vld = 1'b1;
        tick();
        i_matrix_vld = 1'b0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            checks++; if (o_dat_vld !== 1'b1) begin errors++; $display("FAIL bp_vld cyc=%0d got=%b exp=1", c, o_dat_vld); end
            checks++; if (o_dat !== 32'(idx)) begin errors++; $display("FAIL bp_dat cyc=%0d got=%0d exp=%0d", c, o_dat, idx); end
            checks++; if (o_row !== 2'(idx / 4) || o_col !== 2'(idx % 4)) begin errors++; $display("FAIL bp_idx cyc=%0d got=%0d/%0d exp=%0d/%0d", c, o_row, o_col, idx / 4, idx % 4); end
            checks++; if (o_last !== (idx == 15)) begin errors++; $display("FAIL bp_last cyc=%0d got=%b exp=%b", c, o_last, (idx == 15)); end
            i_dat_rdy = (c % 2 == 0);
            tick();
            if (i_dat_rdy) idx++;
        end
        i_dat_rdy = 1'b0;
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL bp_end got=%b exp=0", o_dat_vld); end
    endtask

    task automatic test_drop();
        i_dat_rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            i_matrix = seq_mat(16 * p); i_matrix_vld = 1'b1;
            tick();
            i_matrix_vld = 1'b0;
            checks++; if (o_drop !== (p == 2)) begin errors++; $display("FAIL drop_pulse p=%0d got=%b exp=%b", p, o_drop, (p == 2)); end
            checks++; if (o_drop_cnt !== 8'((p == 2) ? 1 : 0)) begin errors++; $display("FAIL drop_cnt p=%0d got=%0d exp=%0d", p, o_drop_cnt, (p == 2) ? 1 : 0); end
            tick();
            checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL drop_oneshot p=%0d got=%b exp=0", p, o_drop); end
        end
        for (int b = 0; b < 32; b++) begin
            checks++; if (o_dat_vld !== 1'b1) begin errors++; $display("FAIL drop_vld beat=%0d got=%b exp=1", b, o_dat_vld); end
            checks++; if (o_dat !== 32'(b)) begin errors++; $display("FAIL drop_dat beat=%0d got=%0d exp=%0d", b, o_dat, b); end
            i_dat_rdy = 1'b1;
            tick();
        end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL drop_end got=%b exp=0", o_dat_vld); end
        checks++; if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt_end got=%0d exp=1", o_drop_cnt); end
    endtask

    task automatic test_coincident();
        i_dat_rdy = 1'b0;
        i_matrix = seq_mat(0);  i_matrix_vld = 1'b1; tick();
        i_matrix = seq_mat(16); i_matrix_vld = 1'b1; tick();
        i_matrix_vld = 1'b0;
        for (int b = 0; b < 48; b++) begin
            checks++; if (o_dat_vld !== 1'b1) begin errors++; $display("FAIL coin_vld beat=%0d got=%b exp=1", b, o_dat_vld); end
            checks++; if (o_dat !== 32'(b)) begin errors++; $display("FAIL coin_dat beat=%0d got=%0d exp=%0d", b, o_dat, b); end
            checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL coin_drop beat=%0d got=%b exp=0", b, o_drop); end
            i_dat_rdy = 1'b1;
            i_matrix_vld = (b == 15);
            if (b == 15) i_matrix = seq_mat(32);
            tick();
            i_matrix_vld = 1'b0;
        end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL coin_end got=%b exp=0", o_dat_vld); end
        checks++; if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL coin_cnt got=%0d exp=1", o_drop_cnt); end
    endtask

    task automatic test_width();
        mat_t m;
        logic [31:0] exp_v [4];
        m = '0;
        m[0][0] = 60'h100_0000_0005;
        m[0][1] = 60'd7;
        m[0][2] = 60'h1_0000_0000;
        m[0][3] = 60'h800_0000_0000_0003;
`ifdef SA_OUT_SER_SAT_EN
        exp_v[0] = 32'hFFFF_FFFF; exp_v[1] = 32'd7; exp_v[2] = 32'hFFFF_FFFF; exp_v[3] = 32'hFFFF_FFFF;
`else
        exp_v[0] = 32'd5; exp_v[1] = 32'd7; exp_v[2] = 32'd0; exp_v[3] = 32'd3;
`endif
        i_dat_rdy = 1'b1;
        i_matrix = m; i_matrix_vld = 1'b1;
        tick();
        i_matrix_vld = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (b < 4) begin
                checks++; if (o_dat !== exp_v[b]) begin errors++; $display("FAIL width_dat beat=%0d got=%h exp=%h", b, o_dat, exp_v[b]); end
            end else begin
                checks++; if (o_dat !== 32'd0) begin errors++; $display("FAIL width_zero beat=%0d got=%h exp=0", b, o_dat); end
            end
            tick();
        end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL width_end got=%b exp=0", o_dat_vld); end
    endtask

    task automatic test_midreset();
        i_dat_rdy = 1'b0;
        i_matrix = seq_mat(0);  i_matrix_vld = 1'b1; tick();
        i_matrix = seq_mat(16); i_matrix_vld = 1'b1; tick();
        i_matrix_vld = 1'b0;
        i_dat_rdy = 1'b1;
        for (int b = 0; b < 7; b++) tick();
        checks++; if (o_dat !== 32'd7 || o_dat_vld !== 1'b1) begin errors++; $display("FAIL mrst_beat7 got=%0d/%b exp=7/1", o_dat, o_dat_vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL mrst_vld got=%b exp=0", o_dat_vld); end
        checks++; if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL mrst_cnt got=%0d exp=0", o_drop_cnt); end
        checks++; if (o_dat !== 32'd0 || o_row !== 2'd0 || o_col !== 2'd0 || o_last !== 1'b0) begin errors++; $display("FAIL mrst_outs got=%h/%0d/%0d/%b exp=0/0/0/0", o_dat, o_row, o_col, o_last); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL mrst_idle cyc=%0d got=%b exp=0", c, o_dat_vld); end
        end
        i_matrix = seq_mat(64); i_matrix_vld = 1'b1;
        tick();
        i_matrix_vld = 1'b0;
        for (int b = 0; b < 16; b++) begin
            checks++; if (o_dat_vld !== 1'b1 || o_dat !== 32'(64 + b)) begin errors++; $display("FAIL mrst_dat beat=%0d got=%0d/%b exp=%0d/1", b, o_dat, o_dat_vld, 64 + b); end
            checks++; if (o_row !== 2'(b / 4) || o_col !== 2'(b % 4)) begin errors++; $display("FAIL mrst_idx beat=%0d got=%0d/%0d exp=%0d/%0d", b, o_row, o_col, b / 4, b % 4); end
            tick();
        end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL mrst_end got=%b exp=0", o_dat_vld); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_coincident();
        test_width();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
